// File: rtl/mmcm_reset_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mmcm_reset_sequencer_if : MMCM control/status and staged-reset bundle     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface mmcm_reset_sequencer_if;
  logic       soft_reset;
  logic       locked;
  logic       mmcm_rst;
  logic       sys_reset_n;
  logic       core_reset_n;
  logic       ready;
  logic [2:0] state;
  logic [7:0] retry_cnt;
  logic       fail;

  modport master (
    input  soft_reset, locked,
    output mmcm_rst, sys_reset_n, core_reset_n, ready, state, retry_cnt, fail
  );

  modport slave (
    output soft_reset, locked,
    input  mmcm_rst, sys_reset_n, core_reset_n, ready, state, retry_cnt, fail
  );
endinterface
`default_nettype wire

// File: rtl/mmcm_reset_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mmcm_reset_sequencer : MMCM reset/lock supervisor with staged releases.   |
// | Optional macro MMCM_RETRY_LIMIT_EN adds a terminal FAIL state.           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mmcm_reset_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 256,
  parameter int STAGE_GAP     = 16,
  parameter int MAX_RETRIES   = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  mmcm_reset_sequencer_if.master bus
);

  localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CD  = (STABLE_CYCLES > STAGE_GAP) ? STABLE_CYCLES : STAGE_GAP;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP - 1);

  localparam logic [2:0] ST_PWR_RST   = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_STABLE    = 3'd2;
  localparam logic [2:0] ST_REL_SYS   = 3'd3;
  localparam logic [2:0] ST_RUN       = 3'd4;
`ifdef MMCM_RETRY_LIMIT_EN
  localparam logic [2:0] ST_FAIL      = 3'd5;
  localparam logic [7:0] RETRY_LIMIT  = 8'(MAX_RETRIES);
`endif

  logic             locked_meta_q, locked_meta_d;
  logic             locked_s_q, locked_s_d;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic [7:0]       retry_cnt_q, retry_cnt_d;
  logic [7:0]       retry_inc;
  logic             mmcm_rst_q, mmcm_rst_d;
  logic             sys_reset_n_q, sys_reset_n_d;
  logic             core_reset_n_q, core_reset_n_d;
  logic             ready_q, ready_d;
`ifdef MMCM_RETRY_LIMIT_EN
  logic             fail_q, fail_d;
`endif

  // LOCKED is asynchronous; only locked_s_q is used by the state logic.
  always_comb begin
    locked_meta_d = bus.locked;
    locked_s_d    = locked_meta_q;
  end

  always_comb begin
    state_d     = state_q;
    retry_cnt_d = retry_cnt_q;
    retry_inc   = (retry_cnt_q == 8'hFF) ? 8'hFF : retry_cnt_q + 8'd1;

    case (state_q)
      ST_PWR_RST: begin
        if (counter_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (bus.soft_reset) begin
          state_d = ST_PWR_RST;
        end else if (locked_s_q) begin
          state_d = ST_STABLE;
        end else if (counter_q == TIMEOUT_LAST) begin
          retry_cnt_d = retry_inc;
`ifdef MMCM_RETRY_LIMIT_EN
          if (retry_inc >= RETRY_LIMIT) state_d = ST_FAIL;
          else                          state_d = ST_PWR_RST;
`else
          state_d = ST_PWR_RST;
`endif
        end
      end
      ST_STABLE: begin
        if (bus.soft_reset)                 state_d = ST_PWR_RST;
        else if (!locked_s_q)               state_d = ST_WAIT_LOCK;
        else if (counter_q == STABLE_LAST)  state_d = ST_REL_SYS;
      end
      ST_REL_SYS: begin
        if (bus.soft_reset || !locked_s_q)  state_d = ST_PWR_RST;
        else if (counter_q == GAP_LAST)     state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.soft_reset || !locked_s_q)  state_d = ST_PWR_RST;
      end
`ifdef MMCM_RETRY_LIMIT_EN
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
`endif
      default: begin
        state_d = ST_PWR_RST;
      end
    endcase

    // Counter restarts on every state change, so each state times itself.
    counter_d = (state_d != state_q) ? '0 : counter_q + CNT_W'(1);
  end

  // Outputs decode the next state so their flops line up with state_q.
  always_comb begin
    mmcm_rst_d     = (state_d == ST_PWR_RST);
    sys_reset_n_d  = (state_d == ST_REL_SYS) || (state_d == ST_RUN);
    core_reset_n_d = (state_d == ST_RUN);
    ready_d        = (state_d == ST_RUN);
`ifdef MMCM_RETRY_LIMIT_EN
    fail_d         = (state_d == ST_FAIL);
    if (state_d == ST_FAIL) mmcm_rst_d = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      locked_meta_q  <= 1'b0;
      locked_s_q     <= 1'b0;
      state_q        <= ST_PWR_RST;
      counter_q      <= '0;
      retry_cnt_q    <= 8'd0;
      mmcm_rst_q     <= 1'b1;
      sys_reset_n_q  <= 1'b0;
      core_reset_n_q <= 1'b0;
      ready_q        <= 1'b0;
`ifdef MMCM_RETRY_LIMIT_EN
      fail_q         <= 1'b0;
`endif
    end else begin
      locked_meta_q  <= locked_meta_d;
      locked_s_q     <= locked_s_d;
      state_q        <= state_d;
      counter_q      <= counter_d;
      retry_cnt_q    <= retry_cnt_d;
      mmcm_rst_q     <= mmcm_rst_d;
      sys_reset_n_q  <= sys_reset_n_d;
      core_reset_n_q <= core_reset_n_d;
      ready_q        <= ready_d;
`ifdef MMCM_RETRY_LIMIT_EN
      fail_q         <= fail_d;
`endif
    end
  end

  assign bus.mmcm_rst     = mmcm_rst_q;
  assign bus.sys_reset_n  = sys_reset_n_q;
  assign bus.core_reset_n = core_reset_n_q;
  assign bus.ready        = ready_q;
  assign bus.state        = state_q;
  assign bus.retry_cnt    = retry_cnt_q;
`ifdef MMCM_RETRY_LIMIT_EN
  assign bus.fail         = fail_q;
`else
  assign bus.fail         = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mmcm_reset_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mmcm_reset_sequencer : directed + random bench with behavioural model  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_mmcm_reset_sequencer;
  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 32;
  localparam int STABLE_CYCLES = 8;
  localparam int STAGE_GAP     = 4;
  localparam int MAX_RETRIES   = 2;
`ifdef MMCM_RETRY_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  mmcm_reset_sequencer_if bus_if ();

  mmcm_reset_sequencer #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .STAGE_GAP    (STAGE_GAP),
    .MAX_RETRIES  (MAX_RETRIES)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Behavioural model: phase number, time spent in phase, retry tally,
  // and the lock value as seen two clocks late.
  int m_phase = 0, m_age = 0, m_retry = 0, m_nxt = 0;
  bit m_hist0 = 0, m_hist1 = 0, m_ls = 0, m_valid = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (!reset_n) begin
      m_phase = 0; m_age = 0; m_retry = 0;
      m_hist0 = 0; m_hist1 = 0; m_valid = 1;
    end else begin
      m_ls = m_hist1; m_hist1 = m_hist0; m_hist0 = bus_if.locked;
      m_nxt = m_phase;
      if (m_phase == 0) begin
        if (m_age + 1 == RST_CYCLES) m_nxt = 1;
      end else if (m_phase == 5) begin
        m_nxt = 5;
      end else if (bus_if.soft_reset) begin
        m_nxt = 0;
      end else if (m_phase == 1) begin
        if (m_ls) m_nxt = 2;
        else if (m_age + 1 == LOCK_TIMEOUT) begin
          if (m_retry < 255) m_retry++;
          m_nxt = (LIMIT_EN && m_retry >= MAX_RETRIES) ? 5 : 0;
        end
      end else if (m_phase == 2) begin
        if (!m_ls) m_nxt = 1;
        else if (m_age + 1 == STABLE_CYCLES) m_nxt = 3;
      end else if (m_phase == 3) begin
        if (!m_ls) m_nxt = 0;
        else if (m_age + 1 == STAGE_GAP) m_nxt = 4;
      end else begin
        if (!m_ls) m_nxt = 0;
      end
      m_age   = (m_nxt == m_phase) ? m_age + 1 : 0;
      m_phase = m_nxt;
    end
  end

  function automatic int dut_vec();
    return {bus_if.state, bus_if.mmcm_rst, bus_if.sys_reset_n, bus_if.core_reset_n,
            bus_if.ready, bus_if.retry_cnt, bus_if.fail};
  endfunction

  function automatic int model_vec();
    bit [2:0] st;
    bit [7:0] rc;
    st = 3'(m_phase);
    rc = 8'(m_retry);
    return {st, (m_phase == 0 || m_phase == 5), (m_phase == 3 || m_phase == 4),
            (m_phase == 4), (m_phase == 4), rc, (m_phase == 5)};
  endfunction

  initial forever begin
    @(negedge clk);
    if (m_valid) chk("cycle_outputs", dut_vec(), model_vec());
  end

  function automatic bit probe(input int sel);
    case (sel)
      0: return bus_if.mmcm_rst;
      1: return bus_if.state == 3'd2;
      2: return bus_if.sys_reset_n && !bus_if.core_reset_n;
      3: return bus_if.ready;
      4: return bus_if.state == 3'd3;
      5: return bus_if.state == 3'd5;
      default: return bus_if.state == 3'd1;
    endcase
  endfunction

  // Returns at the first negedge sample (current one included) where probe == val.
  task automatic wait_until(input int sel, input bit val, input int budget, input string name);
    int n = 0;
    while (probe(sel) != val && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (probe(sel) != val) chk({name, "_wait_timeout"}, 0, 1);
  endtask

  task automatic count_run(input int sel, input int budget, input string name, output int n);
    wait_until(sel, 1'b1, budget, name);
    n = 0;
    while (probe(sel) && n < budget) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  int n, r0, t_prev, t_now;

  initial begin
    bus_if.soft_reset = 1'b0;
    bus_if.locked     = 1'b0;
    reset_n           = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_vector", dut_vec(), 16'b000_1_0_0_0_00000000_0);

    // Normal bring-up; LOCKED already high while MMCM_RST is asserted.
    n = 1;
    reset_n = 1'b1;
    bus_if.locked = 1'b1;
    @(negedge clk);
    while (bus_if.mmcm_rst && n < 20) begin n++; @(negedge clk); end
    chk("bringup_mmcm_pulse_len", n, 4);
    count_run(1, 50, "bringup_stable", n);
    chk("bringup_stable_len", n, 8);
    count_run(2, 50, "bringup_stage", n);
    chk("bringup_stage_gap", n, 4);
    chk("bringup_ready", bus_if.ready, 1);
    chk("bringup_retry", bus_if.retry_cnt, 0);

    // Lock glitch mid-STABLE restarts the full window without an MMCM pulse.
    pulse_reset();
    wait_until(1, 1'b1, 50, "glitch_enter_stable");
    repeat (3) @(negedge clk);
    bus_if.locked = 1'b0;
    repeat (3) @(negedge clk);
    bus_if.locked = 1'b1;
    wait_until(6, 1'b1, 20, "glitch_back_wait");
    count_run(1, 50, "glitch_stable", n);
    chk("glitch_stable_restart_len", n, 8);
    wait_until(3, 1'b1, 50, "glitch_ready");
    chk("glitch_retry", bus_if.retry_cnt, 0);

    // Lock loss in RUN.
    bus_if.locked = 1'b0;
    repeat (3) @(negedge clk);
    chk("runloss_outputs", {bus_if.mmcm_rst, bus_if.sys_reset_n, bus_if.core_reset_n,
                            bus_if.ready}, 4'b1000);
    bus_if.locked = 1'b1;
    wait_until(3, 1'b1, 100, "runloss_relock");

    // SOFT_RESET coincident with LOCKED drop: one pulse only.
    r0 = bus_if.retry_cnt;
    bus_if.soft_reset = 1'b1;
    bus_if.locked = 1'b0;
    @(negedge clk);
    bus_if.soft_reset = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == 1) bus_if.locked = 1'b1;
      if (bus_if.mmcm_rst) n++;
      @(negedge clk);
    end
    chk("soft_pulse_total", n, 4);
    chk("soft_retry_unchanged", bus_if.retry_cnt, r0);

    // RESET_N mid-REL_SYS.
    pulse_reset();
    wait_until(4, 1'b1, 50, "relsys_enter");
    reset_n = 1'b0;
    @(negedge clk);
    chk("relsys_reset_vector", dut_vec(), 16'b000_1_0_0_0_00000000_0);
    reset_n = 1'b1;

    // Timeouts with LOCKED held low.
    bus_if.locked = 1'b0;
    pulse_reset();
    wait_until(0, 1'b0, 20, "to_first_pulse_end");
    t_prev = cyc;
`ifdef MMCM_RETRY_LIMIT_EN
    wait_until(0, 1'b1, 60, "to_pulse1");
    t_now = cyc;
    wait_until(0, 1'b0, 20, "to_pulse1_end");
    chk("to_retry1", bus_if.retry_cnt, 1);
    wait_until(5, 1'b1, 60, "to_fail_enter");
    chk("fail_flag", bus_if.fail, 1);
    chk("fail_mmcm_rst", bus_if.mmcm_rst, 1);
    chk("fail_retry", bus_if.retry_cnt, 2);
    bus_if.soft_reset = 1'b1;
    @(negedge clk);
    bus_if.soft_reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("fail_soft_ignored", bus_if.state, 5);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("fail_cleared_by_reset", {bus_if.fail, bus_if.state}, 4'b0000);
`else
    t_now = 0;
    for (int k = 1; k <= 3; k++) begin
      wait_until(0, 1'b1, 60, "to_pulse");
      if (k > 1) chk("to_period", cyc - t_now, 36);
      t_now = cyc;
      wait_until(0, 1'b0, 20, "to_pulse_end");
      chk("to_retry_count", bus_if.retry_cnt, k);
    end
    repeat (9200) @(negedge clk);
    chk("to_retry_saturated", bus_if.retry_cnt, 255);
`endif

    // Random traffic, checked cycle by cycle against the model.
    bus_if.locked = 1'b1;
    pulse_reset();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      reset_n = ($urandom_range(0, 299) != 0);
      bus_if.soft_reset = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 19) == 0) bus_if.locked = ~bus_if.locked;
    end
    reset_n = 1'b1;
    bus_if.soft_reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
